fish_sprite_render: RTL and testbench

- Downstream consumer of the fish sprite SRAM in the animation datapath.
- Takes the VGA pixel coordinate stream and keeps the fish position and animation frame, advanced once per video frame.
- Generates the read address for the sprite SRAM, which has 1-cycle registered read latency.
- Returns a colour plus an opaque-hit flag to the pixel mixer, with pixel-to-colour latency aligned.

---
 rtl/fish_sprite_render.sv | 127 ++++++++++++
 tb/tb_fish_sprite_render.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fish_sprite_render.sv
// Fish sprite renderer: bounces a sprite horizontally, steps its animation frame per video frame,
// and turns the VGA pixel stream into sprite SRAM reads with a 3-cycle aligned colour/hit output.
module fish_sprite_render #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned SCREEN_W   = 320,
    parameter int unsigned SPRITE_W   = 64,
    parameter int unsigned SPRITE_H   = 32,
    parameter int unsigned FRAMES     = 8,
    parameter int unsigned Y_POS      = 100,
    parameter int unsigned SPEED      = 1,
    parameter int unsigned ANIM_DIV   = 4,
    parameter logic [DATA_WIDTH-1:0] TRANSP = 12'h0F0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    input  logic                  pixel_valid,
    input  logic                  frame_tick,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_en,
    input  logic [DATA_WIDTH-1:0] sram_data,
    output logic [DATA_WIDTH-1:0] rgb_o,
    output logic                  hit_o,
    output logic                  valid_o,
    output logic [9:0]            fish_x_o,
    output logic                  dir_o
);

    localparam int unsigned AnimW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned CntW  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [10:0] XMax  = 11'(SCREEN_W - SPRITE_W);

    typedef enum logic {StRight, StLeft} state_t;

    state_t            state;
    logic [9:0]        fish_x;
    logic [CntW-1:0]   anim_cnt;
    logic [AnimW-1:0]  anim_idx;
    logic              v1, in1, v2, in2;

    // 11-bit views so bounds and subtractions never wrap
    logic [10:0]           xe, px, py, x_plus, col_raw, col, row;
    logic                  in_sprite;
    logic [ADDR_WIDTH-1:0] addr_next;

    always_comb begin
        xe        = {1'b0, fish_x};
        px        = {1'b0, pixel_x};
        py        = {1'b0, pixel_y};
        x_plus    = xe + 11'(SPEED);
        in_sprite = pixel_valid && (px >= xe) && (px < xe + 11'(SPRITE_W)) &&
                    (py >= 11'(Y_POS)) && (py < 11'(Y_POS + SPRITE_H));
        col_raw   = px - xe;
        row       = py - 11'(Y_POS);
        col       = (state == StLeft) ? 11'(SPRITE_W - 1) - col_raw : col_raw;
        addr_next = ADDR_WIDTH'(anim_idx) * ADDR_WIDTH'(SPRITE_W * SPRITE_H) +
                    ADDR_WIDTH'(row) * ADDR_WIDTH'(SPRITE_W) + ADDR_WIDTH'(col);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StRight;
            fish_x   <= '0;
            anim_cnt <= '0;
            anim_idx <= '0;
        end else if (frame_tick) begin
            unique case (state)
                StRight: begin
                    if (x_plus >= XMax) begin
                        fish_x <= XMax[9:0];
                        state  <= StLeft;
                    end else begin
                        fish_x <= fish_x + 10'(SPEED);
                    end
                end
                StLeft: begin
                    if (xe <= 11'(SPEED)) begin
                        fish_x <= '0;
                        state  <= StRight;
                    end else begin
                        fish_x <= fish_x - 10'(SPEED);
                    end
                end
                default: state <= StRight;
            endcase
            if (anim_cnt == CntW'(ANIM_DIV - 1)) begin
                anim_cnt <= '0;
                anim_idx <= (anim_idx == AnimW'(FRAMES - 1)) ? '0 : anim_idx + 1'b1;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end
        end
    end

    // Stage 1 issues the read, stage 2 is the SRAM's own register, stage 3 keys out TRANSP
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_addr <= '0;
            sram_en   <= 1'b0;
            v1        <= 1'b0;
            in1       <= 1'b0;
            v2        <= 1'b0;
            in2       <= 1'b0;
            rgb_o     <= '0;
            hit_o     <= 1'b0;
            valid_o   <= 1'b0;
        end else begin
            if (in_sprite) begin
                sram_addr <= addr_next;
            end
            sram_en <= pixel_valid;
            v1      <= pixel_valid;
            in1     <= in_sprite;
            v2      <= v1;
            in2     <= in1;
            valid_o <= v2;
            hit_o   <= in2 && (sram_data != TRANSP);
            rgb_o   <= (in2 && (sram_data != TRANSP)) ? sram_data : '0;
        end
    end

    assign fish_x_o = fish_x;
    assign dir_o    = (state == StLeft);

endmodule

// File: tb/tb_fish_sprite_render.sv
// Directed bench for fish_sprite_render with a 1-cycle registered SRAM model.
module tb_fish_sprite_render;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_tick = 1'b0;
    logic [15:0] sram_addr;
    logic        sram_en;
    logic [11:0] sram_data = '0;
    logic [11:0] sram_fill = '0;
    logic [11:0] rgb_o;
    logic        hit_o;
    logic        valid_o;
    logic [9:0]  fish_x_o;
    logic        dir_o;

    int total = 0;
    int bad = 0;

    fish_sprite_render dut (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_valid(pixel_valid), .frame_tick(frame_tick), .sram_addr(sram_addr),
        .sram_en(sram_en), .sram_data(sram_data), .rgb_o(rgb_o), .hit_o(hit_o),
        .valid_o(valid_o), .fish_x_o(fish_x_o), .dir_o(dir_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sram_en) sram_data <= sram_fill;

    // All drive tasks start and end at a negedge
    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic drive_pixel(input int x, input int y);
        pixel_x = 10'(x); pixel_y = 10'(y); pixel_valid = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rgb_o !== 12'h0) begin bad++; $display("FAIL reset_rgb: got %0h want 0", rgb_o); end
        total++; if (hit_o !== 1'b0 || valid_o !== 1'b0) begin bad++;
            $display("FAIL reset_hit_valid: got %b%b want 00", hit_o, valid_o); end
        total++; if (fish_x_o !== 10'd0 || dir_o !== 1'b0) begin bad++;
            $display("FAIL reset_pos: got x=%0d dir=%b want x=0 dir=0", fish_x_o, dir_o); end
        total++; if (sram_addr !== 16'd0 || sram_en !== 1'b0) begin bad++;
            $display("FAIL reset_sram: got addr=%0d en=%b want 0 0", sram_addr, sram_en); end
    endtask

    task automatic test_hit();
        sram_fill = 12'h123;
        drive_pixel(5, 100);
        total++; if (sram_addr !== 16'd5 || sram_en !== 1'b1) begin bad++;
            $display("FAIL hit_addr: got addr=%0d en=%b want 5 1", sram_addr, sram_en); end
        repeat (2) @(negedge clk);
        total++; if (rgb_o !== 12'h123 || hit_o !== 1'b1 || valid_o !== 1'b1) begin bad++;
            $display("FAIL hit_out: got rgb=%0h hit=%b v=%b want 123 1 1", rgb_o, hit_o, valid_o); end
        @(negedge clk);
        total++; if (valid_o !== 1'b0 || hit_o !== 1'b0) begin bad++;
            $display("FAIL hit_idle: got v=%b hit=%b want 0 0", valid_o, hit_o); end
    endtask

    task automatic test_transp_and_outside();
        sram_fill = 12'h0F0;
        drive_pixel(10, 100);
        total++; if (sram_addr !== 16'd10) begin bad++;
            $display("FAIL transp_addr: got %0d want 10", sram_addr); end
        repeat (2) @(negedge clk);
        total++; if (rgb_o !== 12'h0 || hit_o !== 1'b0 || valid_o !== 1'b1) begin bad++;
            $display("FAIL transp_out: got rgb=%0h hit=%b v=%b want 0 0 1", rgb_o, hit_o, valid_o); end
        sram_fill = 12'h123;
        drive_pixel(70, 100);
        total++; if (sram_addr !== 16'd10) begin bad++;
            $display("FAIL outside_x_addr: got %0d want 10", sram_addr); end
        repeat (2) @(negedge clk);
        total++; if (rgb_o !== 12'h0 || hit_o !== 1'b0 || valid_o !== 1'b1) begin bad++;
            $display("FAIL outside_x_out: got rgb=%0h hit=%b v=%b want 0 0 1", rgb_o, hit_o, valid_o); end
        drive_pixel(5, 99);
        total++; if (sram_addr !== 16'd10) begin bad++;
            $display("FAIL outside_y_addr: got %0d want 10", sram_addr); end
        repeat (2) @(negedge clk);
        total++; if (hit_o !== 1'b0 || valid_o !== 1'b1) begin bad++;
            $display("FAIL outside_y_out: got hit=%b v=%b want 0 1", hit_o, valid_o); end
    endtask

    task automatic test_bounce();
        ticks(256);
        total++; if (fish_x_o !== 10'd256 || dir_o !== 1'b1) begin bad++;
            $display("FAIL bounce_right_edge: got x=%0d dir=%b want 256 1", fish_x_o, dir_o); end
        // 256 ticks leave anim_idx at 0, so only the mirrored column remains
        sram_fill = 12'h456;
        drive_pixel(256, 100);
        total++; if (sram_addr !== 16'd63) begin bad++;
            $display("FAIL bounce_mirror_addr: got %0d want 63", sram_addr); end
        repeat (2) @(negedge clk);
        total++; if (rgb_o !== 12'h456 || hit_o !== 1'b1) begin bad++;
            $display("FAIL bounce_mirror_out: got rgb=%0h hit=%b want 456 1", rgb_o, hit_o); end
        ticks(1);
        total++; if (fish_x_o !== 10'd255 || dir_o !== 1'b1) begin bad++;
            $display("FAIL bounce_step_left: got x=%0d dir=%b want 255 1", fish_x_o, dir_o); end
        ticks(254);
        total++; if (fish_x_o !== 10'd1 || dir_o !== 1'b1) begin bad++;
            $display("FAIL bounce_near_left: got x=%0d dir=%b want 1 1", fish_x_o, dir_o); end
        ticks(1);
        total++; if (fish_x_o !== 10'd0 || dir_o !== 1'b0) begin bad++;
            $display("FAIL bounce_left_edge: got x=%0d dir=%b want 0 0", fish_x_o, dir_o); end
    endtask

    task automatic test_anim();
        // 512 ticks so far: anim_cnt=0, anim_idx=0, x=0 moving right
        ticks(4);
        drive_pixel(4, 100);
        total++; if (sram_addr !== 16'd2048) begin bad++;
            $display("FAIL anim_idx1_addr: got %0d want 2048", sram_addr); end
        ticks(24);
        drive_pixel(28, 100);
        total++; if (sram_addr !== 16'd14336) begin bad++;
            $display("FAIL anim_idx7_addr: got %0d want 14336", sram_addr); end
        ticks(4);
        drive_pixel(32, 101);
        total++; if (sram_addr !== 16'd64) begin bad++;
            $display("FAIL anim_wrap_addr: got %0d want 64", sram_addr); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tick_coincident();
        pulse_reset();
        pixel_x = 10'd3; pixel_y = 10'd100; pixel_valid = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        total++; if (sram_addr !== 16'd3) begin bad++;
            $display("FAIL tick_old_x_addr: got %0d want 3", sram_addr); end
        pixel_x = 10'd1;
        @(negedge clk);
        total++; if (sram_addr !== 16'd0 || fish_x_o !== 10'd1) begin bad++;
            $display("FAIL tick_new_x_addr: got addr=%0d x=%0d want 0 1", sram_addr, fish_x_o); end
        pixel_x = 10'd3;
        @(negedge clk);
        pixel_valid = 1'b0;
        total++; if (sram_addr !== 16'd2) begin bad++;
            $display("FAIL tick_back_to_back_addr: got %0d want 2", sram_addr); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        logic exp_v;
        ticks(3);
        for (int k = 0; k < 14; k++) begin
            exp_v = ((k >= 3) && (k <= 5)) || (k >= 9);
            if (k >= 3) begin
                total++; if (valid_o !== exp_v) begin bad++;
                    $display("FAIL midreset_valid_%0d: got %b want %b", k, valid_o, exp_v); end
            end
            if (k == 6) begin
                total++; if (fish_x_o !== 10'd0 || dir_o !== 1'b0) begin bad++;
                    $display("FAIL midreset_pos: got x=%0d dir=%b want 0 0", fish_x_o, dir_o); end
            end
            pixel_x = 10'(k); pixel_y = 10'd100; pixel_valid = 1'b1;
            reset = (k == 5);
            @(negedge clk);
        end
        reset = 1'b0;
        pixel_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hit();
        test_transp_and_outside();
        test_bounce();
        test_anim();
        test_tick_coincident();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
